// File: rtl/seg_scan_decoder.sv
// Scans a multiplexed active-low 7-segment bus and recovers the four digit codes.
// A digit is accepted once its {select, segments, dp} sample has been stable for STABLE_CNT clocks.
module seg_scan_decoder #(
   parameter int unsigned STABLE_CNT = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [6:0]  i_seg,
   input  logic        i_dp,
   input  logic [3:0]  i_sel,
   output logic [15:0] o_digits,
   output logic [3:0]  o_dps,
   output logic [3:0]  o_err,
   output logic        o_frame_valid,
   output logic        o_sel_err
);

   logic [11:0] smp;
   logic [11:0] prev_q, prev_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [15:0] digits_q, digits_d;
   logic [3:0]  dps_q, dps_d;
   logic [3:0]  err_q, err_d;
   logic [3:0]  seen_q, seen_d;
   logic        fv_q, fv_d;
   logic        sel_err_q, sel_err_d;

   logic        same;
   logic        saturated;
   logic        legal;
   logic [1:0]  idx;
   logic        accept;
   logic [3:0]  code;
   logic        bad_code;
   logic [3:0]  seen_nxt;

   assign smp = {i_sel, i_seg, i_dp};

   always_comb begin
      legal = 1'b1;
      idx   = 2'd0;
      unique case (i_sel)
         4'hE:    idx = 2'd0;
         4'hD:    idx = 2'd1;
         4'hB:    idx = 2'd2;
         4'h7:    idx = 2'd3;
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      bad_code = 1'b0;
      case (i_seg)
         7'h40:   code = 4'h0;
         7'h79:   code = 4'h1;
         7'h24:   code = 4'h2;
         7'h30:   code = 4'h3;
         7'h19:   code = 4'h4;
         7'h12:   code = 4'h5;
         7'h02:   code = 4'h6;
         7'h78:   code = 4'h7;
         7'h00:   code = 4'h8;
         7'h10:   code = 4'h9;
         7'h3F:   code = 4'hA;
         7'h7F:   code = 4'hF;
         default: begin
            code     = 4'hF;
            bad_code = 1'b1;
         end
      endcase
   end

   always_comb begin
      same      = (smp == prev_q);
      saturated = (cnt_q == 8'hFF);
      prev_d    = smp;
      if (!same) begin
         cnt_d = 8'd1;
      end else if (saturated) begin
         cnt_d = cnt_q;
      end else begin
         cnt_d = cnt_q + 8'd1;
      end

      // A saturated run keeps cnt at 255 and must not re-trigger when STABLE_CNT is 255.
      accept    = legal && (cnt_d == 8'(STABLE_CNT)) && !(same && saturated);
      sel_err_d = (cnt_d == 8'd1) && !legal && (i_sel != 4'hF);

      digits_d = digits_q;
      dps_d    = dps_q;
      err_d    = err_q;
      seen_d   = seen_q;
      fv_d     = 1'b0;
      seen_nxt = seen_q | (4'b0001 << idx);
      if (accept) begin
         digits_d[{idx, 2'b00} +: 4] = code;
         dps_d[idx]                  = ~i_dp;
         err_d[idx]                  = bad_code;
         if (seen_nxt == 4'hF) begin
            fv_d   = 1'b1;
            seen_d = 4'h0;
         end else begin
            seen_d = seen_nxt;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         prev_q    <= 12'hFFF;
         cnt_q     <= 8'd0;
         digits_q  <= 16'hFFFF;
         dps_q     <= 4'h0;
         err_q     <= 4'h0;
         seen_q    <= 4'h0;
         fv_q      <= 1'b0;
         sel_err_q <= 1'b0;
      end else begin
         prev_q    <= prev_d;
         cnt_q     <= cnt_d;
         digits_q  <= digits_d;
         dps_q     <= dps_d;
         err_q     <= err_d;
         seen_q    <= seen_d;
         fv_q      <= fv_d;
         sel_err_q <= sel_err_d;
      end
   end

   assign o_digits      = digits_q;
   assign o_dps         = dps_q;
   assign o_err         = err_q;
   assign o_frame_valid = fv_q;
   assign o_sel_err     = sel_err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: a sample-history model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_seg_scan_decoder;

   localparam int STABLE = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [6:0]  seg = 7'h7F;
   logic        dp  = 1'b1;
   logic [3:0]  sel = 4'hF;
   logic [15:0] o_digits;
   logic [3:0]  o_dps, o_err;
   logic        o_frame_valid, o_sel_err;

   int checks = 0;
   int errors = 0;
   int fv_cnt = 0;
   int se_cnt = 0;
   bit chk_en = 1'b0;

   seg_scan_decoder #(.STABLE_CNT(STABLE)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_seg        (seg),
      .i_dp         (dp),
      .i_sel        (sel),
      .o_digits     (o_digits),
      .o_dps        (o_dps),
      .o_err        (o_err),
      .o_frame_valid(o_frame_valid),
      .o_sel_err    (o_sel_err)
   );

   always #5 clk = ~clk;

   // Model: run length is recounted from the raw sample history.
   logic [11:0] hist[$];
   logic [15:0] exp_digits = 16'hFFFF;
   logic [3:0]  exp_dps = 4'h0, exp_err = 4'h0, exp_seen = 4'h0;
   logic        exp_fv = 1'b0, exp_se = 1'b0;

   localparam logic [6:0] SEGS [12] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                        7'h02, 7'h78, 7'h00, 7'h10, 7'h3F, 7'h7F};
   localparam logic [3:0] CODES [12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
                                         4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hF};

   function automatic int run_len(logic [11:0] s);
      int n = 1;
      for (int i = hist.size() - 1; i >= 0; i--) begin
         if (hist[i] != s) break;
         n++;
      end
      return n;
   endfunction

   function automatic int zeros(logic [3:0] s);
      int z = 0;
      for (int i = 0; i < 4; i++) if (!s[i]) z++;
      return z;
   endfunction

   function automatic int low_idx(logic [3:0] s);
      for (int i = 0; i < 4; i++) if (!s[i]) return i;
      return 0;
   endfunction

   function automatic logic [4:0] dec(logic [6:0] s);
      for (int i = 0; i < 12; i++) if (SEGS[i] == s) return {1'b0, CODES[i]};
      return 5'h1F;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         hist.delete();
         exp_digits <= 16'hFFFF;
         exp_dps    <= 4'h0;
         exp_err    <= 4'h0;
         exp_seen   <= 4'h0;
         exp_fv     <= 1'b0;
         exp_se     <= 1'b0;
      end else begin
         exp_fv <= 1'b0;
         exp_se <= (run_len({sel, seg, dp}) == 1) && (zeros(sel) >= 2);
         if (run_len({sel, seg, dp}) == STABLE && zeros(sel) == 1) begin
            exp_digits[4*low_idx(sel) +: 4] <= dec(seg) & 5'h0F;
            exp_dps[low_idx(sel)]           <= ~dp;
            exp_err[low_idx(sel)]           <= dec(seg) >> 4;
            if ((exp_seen | (4'b0001 << low_idx(sel))) == 4'hF) begin
               exp_fv   <= 1'b1;
               exp_seen <= 4'h0;
            end else begin
               exp_seen <= exp_seen | (4'b0001 << low_idx(sel));
            end
         end
         hist.push_back({sel, seg, dp});
         if (hist.size() > 300) void'(hist.pop_front());
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("digits", 32'(o_digits), 32'(exp_digits));
         chk("dps", 32'(o_dps), 32'(exp_dps));
         chk("err", 32'(o_err), 32'(exp_err));
         chk("frame_valid", 32'(o_frame_valid), 32'(exp_fv));
         chk("sel_err", 32'(o_sel_err), 32'(exp_se));
         if (o_frame_valid === 1'b1) fv_cnt <= fv_cnt + 1;
         if (o_sel_err === 1'b1) se_cnt <= se_cnt + 1;
      end
   end

   task automatic drive(input logic [3:0] s, input logic [6:0] g, input logic d, input int n);
      for (int i = 0; i < n; i++) begin
         sel = s;
         seg = g;
         dp  = d;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic gap();
      drive(4'hF, 7'h7F, 1'b1, 2);
   endtask

   int fv0, se0;

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b1;
      chk("reset_digits", 32'(o_digits), 32'hFFFF);
      chk("reset_flags", 32'({o_dps, o_err, o_frame_valid, o_sel_err}), 32'h0);
      rst = 1'b0;
      gap();

      // Stable for exactly STABLE samples, then held long after.
      drive(4'hE, 7'h24, 1'b0, 4);
      chk("accept_nibble0", 32'(o_digits[3:0]), 32'h2);
      chk("accept_dp0", 32'(o_dps[0]), 32'h1);
      chk("model_nibble0", 32'(exp_digits[3:0]), 32'h2);
      drive(4'hE, 7'h24, 1'b0, 10);
      chk("hold_nibble0", 32'(o_digits), 32'hFFF2);

      // Full scan of four digits.
      gap();
      drive(4'hE, 7'h79, 1'b1, 5); gap();
      drive(4'hD, 7'h30, 1'b1, 5); gap();
      drive(4'hB, 7'h3F, 1'b1, 5); gap();
      drive(4'h7, 7'h7F, 1'b1, 5); gap();
      chk("scan_digits", 32'(o_digits), 32'hFA31);
      chk("model_scan", 32'(exp_digits), 32'hFA31);
      chk("scan_frames", 32'(fv_cnt), 32'd1);

      // Unknown pattern, then a legal one on the same digit.
      drive(4'hD, 7'h55, 1'b1, 4);
      chk("bad_nibble1", 32'(o_digits[7:4]), 32'hF);
      chk("bad_err1", 32'(o_err[1]), 32'h1);
      drive(4'hD, 7'h40, 1'b1, 4);
      chk("fix_nibble1", 32'(o_digits[7:4]), 32'h0);
      chk("fix_err1", 32'(o_err[1]), 32'h0);

      // Glitching segments, then an illegal two-hot select.
      gap();
      for (int k = 0; k < 4; k++) drive(4'hB, (k % 2 == 0) ? 7'h12 : 7'h02, 1'b1, 3);
      se0 = se_cnt;
      drive(4'hC, 7'h40, 1'b1, 6);
      chk("glitch_digits", 32'(o_digits), 32'hFA01);
      chk("sel_err_once", 32'(se_cnt - se0), 32'd1);
      gap();

      // Three of four digits accepted, then reset mid-run of the fourth.
      drive(4'hE, 7'h40, 1'b1, 5); gap();
      drive(4'hB, 7'h19, 1'b1, 5); gap();
      drive(4'h7, 7'h00, 1'b0, 1);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("async_rst_digits", 32'(o_digits), 32'hFFFF);
      chk("async_rst_flags", 32'({o_dps, o_err, o_frame_valid, o_sel_err}), 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      fv0 = fv_cnt;
      drive(4'h7, 7'h00, 1'b0, 5); gap();
      chk("no_frame_after_rst", 32'(fv_cnt - fv0), 32'd0);
      drive(4'hE, 7'h79, 1'b1, 5); gap();
      drive(4'hD, 7'h24, 1'b1, 5); gap();
      chk("still_no_frame", 32'(fv_cnt - fv0), 32'd0);
      drive(4'hB, 7'h30, 1'b1, 5); gap();
      chk("frame_after_rescan", 32'(fv_cnt - fv0), 32'd1);
      chk("rescan_digits", 32'(o_digits), 32'h8321);
      chk("rescan_dps", 32'(o_dps), 32'h8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
